// File: rtl/apb_regbank_pkg.sv
// Shared types and helpers for the parametrised APB register bank:
// transfer FSM states, wait counter width and the interrupt register offsets.
package apb_regbank_pkg;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } apb_state_e;

   localparam int unsigned CNT_W = 2;

   function automatic logic [31:0] status_offset(input int unsigned num_regs);
      return 32'(4 * num_regs);
   endfunction

   function automatic logic [31:0] enable_offset(input int unsigned num_regs);
      return 32'(4 * num_regs + 4);
   endfunction

endpackage

// File: rtl/apb_regbank_param_if.sv
// APB bus bundle between fabric (master) and the register bank (slave).
interface apb_regbank_param_if #(
   parameter int ADDR_WIDTH = 8
) ();
   logic                  PSEL;
   logic                  PENABLE;
   logic                  PWRITE;
   logic [ADDR_WIDTH-1:0] PADDR;
   logic [31:0]           PWDATA;
   logic [31:0]           PRDATA;
   logic                  PREADY;
   logic                  PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb_regbank_irq.sv
// Interrupt status (W1C, hardware set wins over clear), enable register
// and the registered interrupt output.
module apb_regbank_irq #(
   parameter int NUM_IRQ = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_IRQ-1:0] hw_irq_set,
   input  logic               status_we,
   input  logic               enable_we,
   input  logic [NUM_IRQ-1:0] wdata,
   output logic [NUM_IRQ-1:0] status,
   output logic [NUM_IRQ-1:0] enable,
   output logic               irq
);
   logic [NUM_IRQ-1:0] status_q, status_d;
   logic [NUM_IRQ-1:0] enable_q, enable_d;
   logic               irq_q, irq_d;

   // Set is OR-ed in after the clear so a coincident set keeps the bit.
   always_comb begin
      if (status_we) begin
         status_d = (status_q & ~wdata) | hw_irq_set;
      end else begin
         status_d = status_q | hw_irq_set;
      end
      if (enable_we) begin
         enable_d = wdata;
      end else begin
         enable_d = enable_q;
      end
      irq_d = |(status_q & enable_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         status_q <= '0;
         enable_q <= '0;
         irq_q    <= 1'b0;
      end else begin
         status_q <= status_d;
         enable_q <= enable_d;
         irq_q    <= irq_d;
      end
   end

   assign status = status_q;
   assign enable = enable_q;
   assign irq    = irq_q;
endmodule

// File: rtl/apb_regbank_param.sv
// APB slave register bank: NUM_REGS RW registers with write-notify pulses,
// an interrupt status/enable pair and WAIT_STATES programmable wait states.
module apb_regbank_param
   import apb_regbank_pkg::*;
#(
   parameter int                            ADDR_WIDTH  = 8,
   parameter int                            NUM_REGS    = 4,
   parameter int                            REG_WIDTH   = 32,
   parameter logic [NUM_REGS*REG_WIDTH-1:0] RESET_VAL   = '0,
   parameter int                            WAIT_STATES = 0,
   parameter int                            NUM_IRQ     = 8
) (
   input  logic                          RegClk,
   input  logic                          RegResetN,
   apb_regbank_param_if.slave            apb,
   output logic [NUM_REGS*REG_WIDTH-1:0] swi_reg,
   output logic [NUM_REGS-1:0]           swi_wr_pulse,
   input  logic [NUM_IRQ-1:0]            hw_irq_set,
   output logic                          irq
);
   localparam int DW = (REG_WIDTH > NUM_IRQ) ? REG_WIDTH : NUM_IRQ;

   apb_state_e            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  write_q, write_d;
   logic [DW-1:0]         wdata_q, wdata_d;
   logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;

   logic [31:0]         addr_ext_s;
   logic [NUM_REGS-1:0] reg_hit_s;
   logic [NUM_REGS-1:0] reg_we_s;
   logic                status_hit_s;
   logic                enable_hit_s;
   logic                err_s;
   logic                pready_s;
   logic                commit_s;
   logic                status_we_s;
   logic                enable_we_s;
   logic [31:0]         reg_ext_s [NUM_REGS];
   logic [31:0]         rd_mux_s;
   logic [NUM_IRQ-1:0]  status_s;
   logic [NUM_IRQ-1:0]  enable_s;

   // FSM state, wait counter and the transfer captured in SETUP
   always_ff @(posedge RegClk or negedge RegResetN) begin
      if (!RegResetN) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         write_q    <= 1'b0;
         wdata_q    <= '0;
         wr_pulse_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         write_q    <= write_d;
         wdata_q    <= wdata_d;
         wr_pulse_q <= wr_pulse_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      write_d = write_q;
      wdata_d = wdata_q;
      case (state_q)
         IDLE: begin
            if (apb.PSEL && !apb.PENABLE) begin
               state_d = ACCESS;
               cnt_d   = CNT_W'(WAIT_STATES);
               addr_d  = apb.PADDR;
               write_d = apb.PWRITE;
               wdata_d = apb.PWDATA[DW-1:0];
            end else begin
               state_d = IDLE;
            end
         end
         ACCESS: begin
            // Master dropped PSEL/PENABLE mid-transfer: abandon without effect.
            if (!(apb.PSEL && apb.PENABLE)) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      pready_s    = (state_q == ACCESS) && (cnt_q == '0) && apb.PSEL && apb.PENABLE;
      commit_s    = pready_s && write_q && !err_s;
      reg_we_s    = reg_hit_s & {NUM_REGS{commit_s}};
      status_we_s = commit_s && status_hit_s;
      enable_we_s = commit_s && enable_hit_s;
      wr_pulse_d  = reg_we_s;
   end

   assign apb.PREADY  = pready_s;
   assign apb.PSLVERR = pready_s && err_s;
   assign apb.PRDATA  = (pready_s && !write_q && !err_s) ? rd_mux_s : 32'h0;

   // Only word-aligned mapped offsets hit, so misalignment falls out as an error.
   assign addr_ext_s = 32'(addr_q);
   always_comb begin
      reg_hit_s = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         reg_hit_s[i] = (addr_ext_s == 32'(4 * i));
      end
      status_hit_s = (addr_ext_s == status_offset(NUM_REGS));
      enable_hit_s = (addr_ext_s == enable_offset(NUM_REGS));
      err_s        = !(|reg_hit_s || status_hit_s || enable_hit_s);
   end

   always_comb begin
      rd_mux_s = 32'h0;
      for (int i = 0; i < NUM_REGS; i++) begin
         rd_mux_s = rd_mux_s | (reg_hit_s[i] ? reg_ext_s[i] : 32'h0);
      end
      rd_mux_s = rd_mux_s | (status_hit_s ? 32'(status_s) : 32'h0)
                          | (enable_hit_s ? 32'(enable_s) : 32'h0);
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
      logic [REG_WIDTH-1:0] reg_q, reg_d;

      always_comb begin
         if (reg_we_s[g]) begin
            reg_d = wdata_q[REG_WIDTH-1:0];
         end else begin
            reg_d = reg_q;
         end
      end

      always_ff @(posedge RegClk or negedge RegResetN) begin
         if (!RegResetN) begin
            reg_q <= RESET_VAL[g*REG_WIDTH +: REG_WIDTH];
         end else begin
            reg_q <= reg_d;
         end
      end

      assign swi_reg[g*REG_WIDTH +: REG_WIDTH] = reg_q;
      assign reg_ext_s[g] = 32'(reg_q);
   end

   assign swi_wr_pulse = wr_pulse_q;

   apb_regbank_irq #(
      .NUM_IRQ (NUM_IRQ)
   ) u_irq (
      .clk        (RegClk),
      .rst_n      (RegResetN),
      .hw_irq_set (hw_irq_set),
      .status_we  (status_we_s),
      .enable_we  (enable_we_s),
      .wdata      (wdata_q[NUM_IRQ-1:0]),
      .status     (status_s),
      .enable     (enable_s),
      .irq        (irq)
   );
endmodule

// File: tb/tb_apb_regbank_param.sv
// Bench for apb_regbank_param: a zero-wait 32-bit bank (A) and a 3-wait
// 5-bit bank (B) on one clock, checked against tables and a reference model.
module tb_apb_regbank_param;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        psel, penable, pwrite, sel_b;
   logic [7:0]  paddr;
   logic [31:0] pwdata;
   logic [7:0]  hw_a, hw_b;
   logic        pready, pslverr;
   logic [31:0] prdata;

   logic [127:0] swi_reg_a;
   logic [3:0]   pulse_a;
   logic         irq_a;
   logic [19:0]  swi_reg_b;
   logic [3:0]   pulse_b;
   logic         irq_b;

   apb_regbank_param_if #(.ADDR_WIDTH(8)) a_if ();
   apb_regbank_param_if #(.ADDR_WIDTH(8)) b_if ();

   assign a_if.PSEL    = psel & ~sel_b;
   assign a_if.PENABLE = penable & ~sel_b;
   assign a_if.PWRITE  = pwrite;
   assign a_if.PADDR   = paddr;
   assign a_if.PWDATA  = pwdata;
   assign b_if.PSEL    = psel & sel_b;
   assign b_if.PENABLE = penable & sel_b;
   assign b_if.PWRITE  = pwrite;
   assign b_if.PADDR   = paddr;
   assign b_if.PWDATA  = pwdata;

   assign pready  = sel_b ? b_if.PREADY  : a_if.PREADY;
   assign pslverr = sel_b ? b_if.PSLVERR : a_if.PSLVERR;
   assign prdata  = sel_b ? b_if.PRDATA  : a_if.PRDATA;

   apb_regbank_param #(
      .ADDR_WIDTH (8), .NUM_REGS (4), .REG_WIDTH (32),
      .RESET_VAL  (128'h0000_0000_CAFE_0003_0000_0000_1234_5678),
      .WAIT_STATES(0), .NUM_IRQ (8)
   ) dut_a (
      .RegClk (clk), .RegResetN (rst_n), .apb (a_if),
      .swi_reg (swi_reg_a), .swi_wr_pulse (pulse_a),
      .hw_irq_set (hw_a), .irq (irq_a)
   );

   apb_regbank_param #(
      .ADDR_WIDTH (8), .NUM_REGS (4), .REG_WIDTH (5),
      .RESET_VAL  (20'h0001F),
      .WAIT_STATES(3), .NUM_IRQ (8)
   ) dut_b (
      .RegClk (clk), .RegResetN (rst_n), .apb (b_if),
      .swi_reg (swi_reg_b), .swi_wr_pulse (pulse_b),
      .hw_irq_set (hw_b), .irq (irq_b)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model of bank A: registers, status and enable as plain arrays.
   localparam logic [31:0] RST_A [4] = '{32'h1234_5678, 32'h0, 32'hCAFE_0003, 32'h0};
   logic [31:0] regs_m [4];
   logic [7:0]  stat_m, en_m;

   function automatic void model_reset();
      for (int i = 0; i < 4; i++) regs_m[i] = RST_A[i];
      stat_m = 8'h00;
      en_m   = 8'h00;
   endfunction

   function automatic void model_a(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                                   output logic [31:0] rd, output logic err, output logic [3:0] pulse);
      rd = 32'h0; err = 1'b0; pulse = 4'h0;
      if (addr[1:0] != 2'b00 || addr > 8'h14) begin
         err = 1'b1;
      end else if (addr < 8'h10) begin
         if (wr) begin
            regs_m[addr[3:2]] = wd;
            pulse[addr[3:2]] = 1'b1;
         end else begin
            rd = regs_m[addr[3:2]];
         end
      end else if (addr == 8'h10) begin
         if (wr) stat_m = stat_m & ~wd[7:0];
         else rd = {24'h0, stat_m};
      end else begin
         if (wr) en_m = wd[7:0];
         else rd = {24'h0, en_m};
      end
   endfunction

   // One APB transfer on the selected bank; entered and left at posedge+1.
   task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err, output int cyc);
      bit done = 1'b0;
      rd = 32'h0; err = 1'b0; cyc = 1;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
      @(negedge clk);
      check("setup_pready", pready, 1'b0);
      @(posedge clk); #1;
      penable = 1'b1;
      for (int k = 0; k < 8 && !done; k++) begin
         @(negedge clk);
         cyc++;
         if (pready) begin
            done = 1'b1; rd = prdata; err = pslverr;
         end else begin
            check("wait_prdata", {pslverr, prdata}, 33'h0);
         end
      end
      if (!done) begin
         checks++; failures++;
         $display("FAIL xfer_timeout: got no PREADY expected PREADY within 8 cycles");
      end
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic pulse_hw(input logic [7:0] v);
      hw_a = v;
      @(posedge clk); #1;
      hw_a = 8'h00;
      stat_m = stat_m | v;
   endtask

   // Bank A transfer checked end to end against the model.
   task automatic op_a(input string tag, input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err);
      logic [31:0] erd; logic eerr; logic [3:0] ep; int cyc;
      sel_b = 1'b0;
      model_a(wr, addr, wd, erd, eerr, ep);
      xfer(wr, addr, wd, rd, err, cyc);
      check({tag, "_cycles"}, cyc, 2);
      check({tag, "_err"}, err, eerr);
      check({tag, "_rd"}, rd, erd);
      @(negedge clk);
      check({tag, "_pulse"}, pulse_a, ep);
      @(negedge clk);
      check({tag, "_pulse_once"}, pulse_a, 4'h0);
      check({tag, "_irq"}, irq_a, |(stat_m & en_m));
      check({tag, "_regs"}, swi_reg_a, {regs_m[3], regs_m[2], regs_m[1], regs_m[0]});
      @(posedge clk); #1;
   endtask

   task automatic op_b(input string tag, input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic [3:0] exp_pulse);
      logic [31:0] rd; logic err; int cyc;
      sel_b = 1'b1;
      xfer(wr, addr, wd, rd, err, cyc);
      check({tag, "_cycles"}, cyc, 5);
      check({tag, "_err"}, err, 1'b0);
      check({tag, "_rd"}, rd, exp_rd);
      @(negedge clk);
      check({tag, "_pulse"}, pulse_b, exp_pulse);
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic        wr;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t vecs [13];

   initial begin
      logic [31:0] rd; logic err; int cyc;
      vecs[0]  = '{1'b0, 8'h00, 32'h0000_0000, 32'h1234_5678, 1'b0};
      vecs[1]  = '{1'b0, 8'h08, 32'h0000_0000, 32'hCAFE_0003, 1'b0};
      vecs[2]  = '{1'b1, 8'h04, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
      vecs[3]  = '{1'b0, 8'h04, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
      vecs[4]  = '{1'b0, 8'h40, 32'h0000_0000, 32'h0000_0000, 1'b1};
      vecs[5]  = '{1'b1, 8'h02, 32'h1111_1111, 32'h0000_0000, 1'b1};
      vecs[6]  = '{1'b1, 8'h40, 32'h2222_2222, 32'h0000_0000, 1'b1};
      vecs[7]  = '{1'b0, 8'h02, 32'h0000_0000, 32'h0000_0000, 1'b1};
      vecs[8]  = '{1'b1, 8'h0C, 32'h0000_00A5, 32'h0000_0000, 1'b0};
      vecs[9]  = '{1'b0, 8'h0C, 32'h0000_0000, 32'h0000_00A5, 1'b0};
      vecs[10] = '{1'b0, 8'h10, 32'h0000_0000, 32'h0000_0000, 1'b0};
      vecs[11] = '{1'b1, 8'h14, 32'hFFFF_FF81, 32'h0000_0000, 1'b0};
      vecs[12] = '{1'b0, 8'h14, 32'h0000_0000, 32'h0000_0081, 1'b0};

      psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 8'h00; pwdata = 32'h0;
      sel_b = 1'b0; hw_a = 8'h00; hw_b = 8'h00;
      model_reset();

      repeat (2) @(negedge clk);
      check("rst_regs_a", swi_reg_a, 128'h0000_0000_CAFE_0003_0000_0000_1234_5678);
      check("rst_regs_b", swi_reg_b, 20'h0001F);
      check("rst_pulse", {pulse_a, pulse_b}, 8'h00);
      check("rst_irq", {irq_a, irq_b}, 2'b00);
      check("rst_bus_a", {a_if.PREADY, a_if.PSLVERR, a_if.PRDATA}, 34'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 13; i++) begin
         op_a($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, err);
         check($sformatf("vec%0d_tbl_rd", i), rd, vecs[i].exp_rd);
         check($sformatf("vec%0d_tbl_err", i), err, vecs[i].exp_err);
      end

      // Interrupt: rise latency, set-beats-clear, then clear and fall.
      sel_b = 1'b0;
      op_a("en_off", 1'b1, 8'h14, 32'h0, rd, err);
      pulse_hw(8'h04);
      xfer(1'b1, 8'h14, 32'h0000_0004, rd, err, cyc);
      en_m = 8'h04;
      @(negedge clk);
      check("irq_pre", irq_a, 1'b0);
      @(negedge clk);
      check("irq_rise", irq_a, 1'b1);
      @(posedge clk); #1;
      hw_a = 8'h04;
      xfer(1'b1, 8'h10, 32'h0000_0004, rd, err, cyc);
      hw_a = 8'h00;
      op_a("stat_kept", 1'b0, 8'h10, 32'h0, rd, err);
      check("stat_kept_val", rd, 32'h0000_0004);
      xfer(1'b1, 8'h10, 32'h0000_0004, rd, err, cyc);
      stat_m = 8'h00;
      @(negedge clk);
      check("irq_hold", irq_a, 1'b1);
      @(negedge clk);
      check("irq_fall", irq_a, 1'b0);
      @(posedge clk); #1;

      // Randomised traffic on bank A with interleaved hardware set pulses.
      for (int n = 0; n < 40; n++) begin
         logic wr; logic [7:0] addr; int pick;
         if ($urandom_range(0, 2) == 0) pulse_hw(8'($urandom));
         wr = 1'($urandom_range(0, 1));
         pick = int'($urandom_range(0, 5));
         if (pick < 4) addr = 8'($urandom_range(0, 5) * 4);
         else if (pick == 4) addr = 8'($urandom_range(0, 255));
         else addr = 8'($urandom_range(0, 7) * 4 + 1);
         op_a($sformatf("rnd%0d", n), wr, addr, $urandom, rd, err);
      end

      // Bank B: narrow registers and three wait states.
      op_b("b_rd0", 1'b0, 8'h00, 32'h0, 32'h0000_001F, 4'h0);
      op_b("b_wr0", 1'b1, 8'h00, 32'hFFFF_FFE0, 32'h0, 4'h1);
      op_b("b_rd0z", 1'b0, 8'h00, 32'h0, 32'h0000_0000, 4'h0);
      op_b("b_wr2", 1'b1, 8'h08, 32'h0000_0035, 32'h0, 4'h4);
      op_b("b_rd2", 1'b0, 8'h08, 32'h0, 32'h0000_0015, 4'h0);
      check("b_regs", swi_reg_b, 20'h05400);

      // Reset while a bank B write sits in its wait states.
      sel_b = 1'b1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h04; pwdata = 32'h0000_000A;
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("mid_pready", pready, 1'b0);
      rst_n = 1'b0;
      #1;
      psel = 1'b0; penable = 1'b0;
      check("mid_rst_regs_b", swi_reg_b, 20'h0001F);
      check("mid_rst_pready", pready, 1'b0);
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("mid_rst_no_pulse", pulse_b, 4'h0);
      end
      check("mid_rst_regs_b2", swi_reg_b, 20'h0001F);
      check("mid_rst_regs_a", swi_reg_a, {regs_m[3], regs_m[2], regs_m[1], regs_m[0]});
      check("mid_rst_irq", irq_a, 1'b0);
      @(posedge clk); #1;
      op_b("b_rd1_post", 1'b0, 8'h04, 32'h0, 32'h0000_0000, 4'h0);
      op_a("a_rd0_post", 1'b0, 8'h00, 32'h0, rd, err);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/apb_regbank_param.md
# apb_regbank_param

Parametrised APB slave register bank: the successor of the single-register generated block. It provides NUM_REGS software read-write registers of REG_WIDTH bits, each with a per-register reset value and a one-cycle write-notify pulse. It adds a W1C interrupt status/enable pair driven by hardware set inputs, and programmable APB wait states through an explicit transfer FSM. It sits between the APB fabric and block-level control logic, replacing flat generated register tops where wait states or interrupts are needed.

## Interface
- ADDR_WIDTH, 8, PADDR width (byte address)
- NUM_REGS, 4, read-write registers, 1..16
- REG_WIDTH, 32, bits per RW register, 1..32
- RESET_VAL, all zeros, NUM_REGS*REG_WIDTH packed reset values; reg i at [i*REG_WIDTH +: REG_WIDTH]
- WAIT_STATES, 0, PREADY-low cycles per access, 0..3
- NUM_IRQ, 8, interrupt sources, 1..32
- RegClk  in  1  sole clock
- RegResetN  in  1  asynchronous active-low reset
- PSEL, PENABLE, PWRITE  in  1 each  APB control
- PADDR  in  ADDR_WIDTH  APB address
- PWDATA  in  32  APB write data
- PRDATA  out  32  read data, zero unless PREADY=1 and read
- PREADY  out  1  transfer complete
- PSLVERR  out  1  error, only valid with PREADY=1
- swi_reg  out  NUM_REGS*REG_WIDTH  register contents
- swi_wr_pulse  out  NUM_REGS  one-cycle pulse on the cycle after a register write commits
- hw_irq_set  in  NUM_IRQ  level-sampled set per source
- irq  out  1  OR of (status & enable)

## Operation
- Map (byte offsets): RW reg i at 4*i; IRQ_STATUS at 4*NUM_REGS (W1C); IRQ_ENABLE at 4*NUM_REGS+4 (RW). Any other offset, or PADDR[1:0]!=0, is an error.
- FSM states: IDLE, ACCESS.
  - IDLE: on PSEL&!PENABLE, capture PADDR/PWRITE/PWDATA, load wait counter with WAIT_STATES, and go to ACCESS.
  - ACCESS: while counter!=0, decrement; PREADY=0.
  - ACCESS, counter==0: PREADY=1; commit the write (if PWRITE and no error); go to IDLE.
  - Back-to-back transfers: the next SETUP is taken from IDLE on the cycle after completion.
- ACCESS with PSEL=0 or PENABLE=0 (protocol violation): return to IDLE with no write and PREADY=0.
- Errored write: no state change and no pulse. Errored read: PRDATA=0, PSLVERR=1.
- RW reads return the register zero-extended to 32 bits. Writes take PWDATA[REG_WIDTH-1:0]; upper bits are ignored.
- IRQ_STATUS: bit set when hw_irq_set is high; cleared by writing 1. If set and clear hit the same bit in the same cycle, set wins.
- IRQ_ENABLE and IRQ_STATUS are NUM_IRQ bits, zero-extended on read. irq is registered from the status/enable values.

## Timing
- Reset values: FSM IDLE, counter 0, swi_reg=RESET_VAL, swi_wr_pulse=0, status=0, enable=0, irq=0, PREADY=0, PSLVERR=0, PRDATA=0.
- PREADY/PRDATA/PSLVERR are combinational from the FSM state and captured address. Minimum transfer is 2 cycles (SETUP, ACCESS); total is 2+WAIT_STATES.
- swi_reg updates at the edge ending the PREADY=1 cycle. swi_wr_pulse is high for exactly the following cycle.
- irq is asserted one cycle after status&enable becomes nonzero, and drops one cycle after the clearing write commits.
- Reset asserted mid-transfer: everything returns to reset values immediately. The interrupted write is lost.

## Structure
- Package apb_regbank_pkg holds:
  - FSM state enum (IDLE, ACCESS);
  - offset helper functions for the STATUS/ENABLE locations;
  - the wait counter width constant (2 bits).
- Sub-module apb_regbank_irq holds the W1C status, enable and registered irq. It is instantiated once, and the top feeds it decoded write strobes.
- The top contains the FSM, address decode, RW register array (generate loop) and read mux.

## Test plan
- Default parameters, WAIT_STATES=0: write 0xDEADBEEF to 0x4, then read 0x4. PREADY is high in the second cycle of each transfer; read returns 0xDEADBEEF; swi_wr_pulse[1] pulses once.
- REG_WIDTH=5, RESET_VAL reg0=0x1F: read 0x0 after reset returns 0x0000001F. Write 0xFFFFFFE0, then read returns 0x00000000.
- WAIT_STATES=3: read 0x0. PREADY is low for 3 ACCESS cycles and the transfer completes in 5 cycles.
- Access to 0x40 or 0x2: PSLVERR=1 with PREADY, PRDATA=0, and all registers unchanged.
- Set hw_irq_set[2] and write ENABLE=0x4: irq rises one cycle later. Then W1C 0x4 to STATUS in the same cycle that hw_irq_set[2]=1: the bit stays set. Repeat with hw_irq_set[2]=0: irq falls.
- Assert RegResetN low during a wait-state write: the FSM returns to IDLE, the register holds its reset value, and no pulse is generated.
